mac_sequencer: RTL and testbench

MAC_SEQUENCER -- requirements
Module: mac_sequencer

---
 rtl/mac_sequencer.sv | 219 +++++++++++++++++++++
 tb/tb_mac_sequencer.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_sequencer.sv
// Dot-product sequencer: streams signed operand pairs into an external MAC PE and returns the accumulated result.
// Optional abort input enabled by defining MAC_SEQ_ABORT_EN.
module mac_sequencer #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ACC_WIDTH  = 32,
  parameter int unsigned LEN_WIDTH  = 8,
  parameter int unsigned PE_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  i_reset,
  input  logic                  i_start,
  input  logic [LEN_WIDTH-1:0]  i_length,
  input  logic [DATA_WIDTH-1:0] i_a_data,
  input  logic [DATA_WIDTH-1:0] i_b_data,
  input  logic                  i_valid,
`ifdef MAC_SEQ_ABORT_EN
  input  logic                  i_abort,
`endif
  output logic                  o_ready,
  output logic [DATA_WIDTH-1:0] o_pe_a,
  output logic [DATA_WIDTH-1:0] o_pe_b,
  output logic                  o_pe_enable,
  output logic                  o_pe_clear,
  input  logic [ACC_WIDTH-1:0]  i_pe_result,
  input  logic                  i_pe_overflow,
  output logic [ACC_WIDTH-1:0]  o_result,
  output logic                  o_result_valid,
  input  logic                  i_result_ready,
  output logic                  o_overflow,
  output logic                  o_busy,
  output logic                  o_done
);

  localparam int unsigned DRAIN_W = $clog2(PE_LATENCY + 1) + 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLEAR  = 3'd1,
    S_STREAM = 3'd2,
    S_DRAIN  = 3'd3,
    S_RESULT = 3'd4
  } state_e;

  state_e                state_q, state_d;
  logic [LEN_WIDTH-1:0]  count_q, count_d;
  logic [DRAIN_W-1:0]    drain_q, drain_d;
  logic                  ovf_acc_q, ovf_acc_d;
  logic                  ready_q, ready_d;
  logic [DATA_WIDTH-1:0] pe_a_q, pe_a_d, pe_b_q, pe_b_d;
  logic                  pe_en_q, pe_en_d;
  logic                  pe_clear_q, pe_clear_d;
  logic [ACC_WIDTH-1:0]  result_q, result_d;
  logic                  result_valid_q, result_valid_d;
  logic                  overflow_q, overflow_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  logic beat;
  logic abort;
  logic drain_last;

  assign beat       = (state_q == S_STREAM) && i_valid && ready_q;
  assign drain_last = (drain_q == DRAIN_W'(PE_LATENCY));

`ifdef MAC_SEQ_ABORT_EN
  assign abort = i_abort && ((state_q == S_CLEAR) || (state_q == S_STREAM) || (state_q == S_DRAIN));
`else
  assign abort = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (i_reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (i_start) begin
          state_d = (i_length != '0) ? S_CLEAR : S_RESULT;
        end
      end
      S_CLEAR:  state_d = S_STREAM;
      S_STREAM: begin
        if (beat && (count_q == LEN_WIDTH'(1))) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (drain_last) begin
          state_d = S_RESULT;
        end
      end
      S_RESULT: begin
        if (i_result_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (abort) begin
      state_d = S_IDLE;
    end
  end

  // Output and datapath next values; status flags follow the next state so they line up with it
  always_comb begin
    count_d        = count_q;
    drain_d        = drain_q;
    ovf_acc_d      = ovf_acc_q;
    pe_a_d         = pe_a_q;
    pe_b_d         = pe_b_q;
    result_d       = result_q;
    overflow_d     = overflow_q;
    pe_en_d        = 1'b0;
    done_d         = 1'b0;
    ready_d        = (state_d == S_STREAM);
    busy_d         = (state_d != S_IDLE);
    result_valid_d = (state_d == S_RESULT);
    pe_clear_d     = (state_d == S_CLEAR) || abort;

    unique case (state_q)
      S_IDLE: begin
        if (i_start) begin
          count_d   = i_length;
          drain_d   = '0;
          ovf_acc_d = 1'b0;
          if (i_length == '0) begin
            result_d   = '0;
            overflow_d = 1'b0;
          end
        end
      end
      S_STREAM: begin
        ovf_acc_d = ovf_acc_q | i_pe_overflow;
        if (beat) begin
          pe_a_d  = i_a_data;
          pe_b_d  = i_b_data;
          pe_en_d = 1'b1;
          count_d = count_q - LEN_WIDTH'(1);
        end
      end
      S_DRAIN: begin
        ovf_acc_d = ovf_acc_q | i_pe_overflow;
        drain_d   = drain_q + DRAIN_W'(1);
        if (drain_last) begin
          result_d   = i_pe_result;
          overflow_d = ovf_acc_q | i_pe_overflow;
        end
      end
      S_RESULT: begin
        if (i_result_ready) begin
          done_d = 1'b1;
        end
      end
      default: begin
      end
    endcase

    // An aborted operation issues no further PE work and leaves the last result untouched
    if (abort) begin
      pe_en_d    = 1'b0;
      count_d    = '0;
      result_d   = result_q;
      overflow_d = overflow_q;
    end
  end

  // Datapath and output registers; reset clears the PE in the same cycle
  always_ff @(posedge clk) begin
    if (i_reset) begin
      count_q        <= '0;
      drain_q        <= '0;
      ovf_acc_q      <= 1'b0;
      ready_q        <= 1'b0;
      pe_a_q         <= '0;
      pe_b_q         <= '0;
      pe_en_q        <= 1'b0;
      pe_clear_q     <= 1'b1;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      overflow_q     <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      count_q        <= count_d;
      drain_q        <= drain_d;
      ovf_acc_q      <= ovf_acc_d;
      ready_q        <= ready_d;
      pe_a_q         <= pe_a_d;
      pe_b_q         <= pe_b_d;
      pe_en_q        <= pe_en_d;
      pe_clear_q     <= pe_clear_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
      overflow_q     <= overflow_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
    end
  end

  assign o_ready        = ready_q;
  assign o_pe_a         = pe_a_q;
  assign o_pe_b         = pe_b_q;
  assign o_pe_enable    = pe_en_q;
  assign o_pe_clear     = pe_clear_q;
  assign o_result       = result_q;
  assign o_result_valid = result_valid_q;
  assign o_overflow     = overflow_q;
  assign o_busy         = busy_q;
  assign o_done         = done_q;

endmodule

// File: tb/tb_mac_sequencer.sv
// Bench for mac_sequencer: behavioural MAC PE, randomized operand streams, dot-product reference from the sent pairs.
module tb_mac_sequencer;

  logic        clk = 1'b0;
  logic        i_reset = 1'b1;
  logic        i_start = 1'b0;
  logic [7:0]  i_length = '0;
  logic [7:0]  i_a_data = '0;
  logic [7:0]  i_b_data = '0;
  logic        i_valid = 1'b0;
  logic        i_abort = 1'b0;
  logic        o_ready;
  logic [7:0]  o_pe_a, o_pe_b;
  logic        o_pe_enable, o_pe_clear;
  logic [31:0] i_pe_result;
  logic        i_pe_overflow;
  logic [31:0] o_result;
  logic        o_result_valid;
  logic        i_result_ready = 1'b0;
  logic        o_overflow, o_busy, o_done;

  logic signed [31:0] pe_acc = '0;
  logic               pe_ovf = 1'b0;
  logic               inj_ovf = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;
  int en_cnt, done_cnt, clr_cnt;
  logic [7:0] sb_a[$], sb_b[$];
  int da[$], db[$];

  always #5 clk = ~clk;

  mac_sequencer dut (
    .clk            (clk),
    .i_reset        (i_reset),
    .i_start        (i_start),
    .i_length       (i_length),
    .i_a_data       (i_a_data),
    .i_b_data       (i_b_data),
    .i_valid        (i_valid),
`ifdef MAC_SEQ_ABORT_EN
    .i_abort        (i_abort),
`endif
    .o_ready        (o_ready),
    .o_pe_a         (o_pe_a),
    .o_pe_b         (o_pe_b),
    .o_pe_enable    (o_pe_enable),
    .o_pe_clear     (o_pe_clear),
    .i_pe_result    (i_pe_result),
    .i_pe_overflow  (i_pe_overflow),
    .o_result       (o_result),
    .o_result_valid (o_result_valid),
    .i_result_ready (i_result_ready),
    .o_overflow     (o_overflow),
    .o_busy         (o_busy),
    .o_done         (o_done)
  );

  function automatic longint pe_sum(input logic signed [31:0] acc,
                                    input logic signed [7:0] a, input logic signed [7:0] b);
    return longint'(acc) + longint'(a) * longint'(b);
  endfunction

  function automatic logic sum_ovf(input longint s);
    return (s > 64'sd2147483647) || (s < -64'sd2147483648);
  endfunction

  // Behavioural PE with one-cycle latency
  always @(posedge clk) begin
    if (o_pe_clear) begin
      pe_acc <= '0;
      pe_ovf <= 1'b0;
    end else if (o_pe_enable) begin
      pe_acc <= 32'(pe_sum(pe_acc, o_pe_a, o_pe_b));
      pe_ovf <= pe_ovf | sum_ovf(pe_sum(pe_acc, o_pe_a, o_pe_b));
    end
  end

  assign i_pe_result   = pe_acc;
  assign i_pe_overflow = pe_ovf | inj_ovf;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one cycle and score PE traffic seen in the new cycle
  task automatic tick();
    @(negedge clk);
    if (o_pe_enable) begin
      en_cnt++;
      check("pe_enable_expected", 64'(sb_a.size() != 0), 64'd1);
      if (sb_a.size() != 0) begin
        check("pe_a", 64'(o_pe_a), 64'(sb_a.pop_front()));
        check("pe_b", 64'(o_pe_b), 64'(sb_b.pop_front()));
      end
    end
    if (o_done) done_cnt++;
    if (o_pe_clear) clr_cnt++;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"},    64'(o_ready), 64'd0);
    check({tag, "_pe_en"},    64'(o_pe_enable), 64'd0);
    check({tag, "_valid"},    64'(o_result_valid), 64'd0);
    check({tag, "_ovf"},      64'(o_overflow), 64'd0);
    check({tag, "_busy"},     64'(o_busy), 64'd0);
    check({tag, "_done"},     64'(o_done), 64'd0);
    check({tag, "_pe_a"},     64'(o_pe_a), 64'd0);
    check({tag, "_pe_b"},     64'(o_pe_b), 64'd0);
    check({tag, "_result"},   64'(o_result), 64'd0);
    check({tag, "_pe_clear"}, 64'(o_pe_clear), 64'd1);
  endtask

  // One full operation, starting at a negedge; returns at the negedge of the o_done cycle.
  // gap < 0 selects random idle gaps between beats; inj_at pulses PE overflow before that beat index.
  task automatic run_op(input int len, input int gap, input int rdy_wait, input int inj_at);
    longint sum = 0;
    int sent = 0, cyc = 0, gap_left = 0, w = 0;
    logic signed [7:0] a, b;
    logic exp_ovf = 1'b0;
    logic [31:0] exp_res;
    en_cnt = 0; done_cnt = 0; clr_cnt = 0;
    i_start = 1'b1;
    i_length = 8'(len);
    tick();
    i_start = 1'b0;
    check("busy_after_start", 64'(o_busy), 64'd1);
    while (sent < len && cyc < 2000) begin
      // junk start requests must be ignored while busy
      i_start  = 1'($urandom_range(0, 1));
      i_length = 8'($urandom);
      inj_ovf  = o_ready && (sent == inj_at);
      if (inj_ovf) exp_ovf = 1'b1;
      if (sent > 0 && gap_left > 0) begin
        i_valid  = 1'b0;
        i_a_data = 8'($urandom);
        gap_left--;
        check("ready_in_gap", 64'(o_ready), 64'd1);
      end else begin
        i_valid = 1'b1;
        if (o_ready) begin
          if (da.size() != 0) begin
            a = 8'(da.pop_front());
            b = 8'(db.pop_front());
          end else begin
            a = 8'($urandom);
            b = 8'($urandom);
          end
          i_a_data = a;
          i_b_data = b;
          sb_a.push_back(a);
          sb_b.push_back(b);
          sum += longint'(a) * longint'(b);
          sent++;
          gap_left = (gap < 0) ? int'($urandom_range(0, 3)) : gap;
        end else begin
          i_a_data = 8'($urandom);
          i_b_data = 8'($urandom);
        end
      end
      tick();
      cyc++;
    end
    i_valid = 1'b0;
    inj_ovf = 1'b0;
    i_start = 1'b0;
    check("beats_sent", 64'(sent), 64'(len));
    while (!o_result_valid && w < 20) begin
      tick();
      w++;
    end
    check("result_valid", 64'(o_result_valid), 64'd1);
    if (len > 0) check("drain_latency", 64'(w), 64'd2);
    else         check("zero_len_latency_le2", 64'(w <= 2), 64'd1);
    exp_res = 32'(sum);
    check("result", 64'(o_result), 64'(exp_res));
    check("overflow", 64'(o_overflow), 64'(exp_ovf));
    for (int i = 0; i < rdy_wait; i++) begin
      tick();
      check("hold_valid", 64'(o_result_valid), 64'd1);
      check("hold_result", 64'(o_result), 64'(exp_res));
      check("hold_overflow", 64'(o_overflow), 64'(exp_ovf));
    end
    i_result_ready = 1'b1;
    tick();
    i_result_ready = 1'b0;
    check("done_pulse", 64'(o_done), 64'd1);
    check("valid_after_ack", 64'(o_result_valid), 64'd0);
    check("busy_after_ack", 64'(o_busy), 64'd0);
    check("done_count", 64'(done_cnt), 64'd1);
    check("pe_enable_count", 64'(en_cnt), 64'(len));
    check("pe_clear_count", 64'(clr_cnt), 64'(len > 0));
    check("scoreboard_empty", 64'(sb_a.size()), 64'd0);
  endtask

  initial begin
    en_cnt = 0; done_cnt = 0; clr_cnt = 0;
    repeat (3) tick();
    check_reset_outputs("reset");
    i_reset = 1'b0;
    tick();
    check("pe_clear_released", 64'(o_pe_clear), 64'd0);
    check("idle_busy", 64'(o_busy), 64'd0);

    // Known vectors
    da = '{2, 3, -4};  db = '{5, 6, 7};
    run_op(3, 0, 0, -1);
    da = '{-1, -128};  db = '{-1, -128};
    run_op(2, 4, 0, -1);
    check("known_16385", 64'(o_result), 64'd16385);
    run_op(0, 0, 1, -1);
    run_op(4, -1, 5, -1);
    run_op(5, -1, 1, 2);
    run_op(3, -1, 0, -1);

    // Reset after two of four beats
    en_cnt = 0; done_cnt = 0; clr_cnt = 0;
    i_start = 1'b1; i_length = 8'd4;
    tick();
    i_start = 1'b0;
    i_valid = 1'b1;
    tick();
    for (int i = 0; i < 2; i++) begin
      i_a_data = 8'($urandom);
      i_b_data = 8'($urandom);
      sb_a.push_back(i_a_data);
      sb_b.push_back(i_b_data);
      tick();
    end
    i_valid = 1'b0;
    i_reset = 1'b1;
    tick();
    check_reset_outputs("midstream_reset");
    check("midstream_sb_empty", 64'(sb_a.size()), 64'd0);
    i_reset = 1'b0;
    tick();
    check("midstream_no_done", 64'(done_cnt), 64'd0);
    da = '{3};  db = '{3};
    run_op(1, 0, 0, -1);
    check("after_reset_9", 64'(o_result), 64'd9);

`ifdef MAC_SEQ_ABORT_EN
    // Abort while draining
    en_cnt = 0; done_cnt = 0; clr_cnt = 0;
    i_start = 1'b1; i_length = 8'd1;
    tick();
    i_start = 1'b0;
    i_valid = 1'b1;
    i_a_data = 8'd7; i_b_data = 8'd7;
    tick();
    sb_a.push_back(8'd7); sb_b.push_back(8'd7);
    tick();
    i_valid = 1'b0;
    i_abort = 1'b1;
    tick();
    i_abort = 1'b0;
    check("abort_busy", 64'(o_busy), 64'd0);
    check("abort_pe_clear", 64'(o_pe_clear), 64'd1);
    repeat (4) begin
      tick();
      check("abort_no_valid", 64'(o_result_valid), 64'd0);
    end
    check("abort_no_done", 64'(done_cnt), 64'd0);
    run_op(2, -1, 0, -1);
`endif

    // Randomized back-to-back operations
    for (int k = 0; k < 25; k++) begin
      run_op(int'($urandom_range(0, 12)), -1, int'($urandom_range(0, 3)), -1);
    end
    tick();
    check("final_done_low", 64'(o_done), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
